uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
// - Downstream of the terminal UART MMR block: consumes its one-cycle tx_valid/tx_data
//   byte strobe, buffers bytes in a small FIFO, and serializes each one onto a TX pin.
// - Frame format is 8N1 (8 data bits, no parity, 1 stop bit), LSB first; bit period is
//   set by a clock-cycle divider.
// - No backpressure upstream: bytes arriving while the FIFO is full are dropped and flagged.
// PARAMETERS
// - CLKS_PER_BIT  16  clock cycles per serial bit; legal range >= 2
// - FIFO_DEPTH     8  byte FIFO entries; power of 2, >= 2
// PORTS
// - i_clk       in   1           system clock
// - i_rst       in   1           asynchronous, active-high reset
// - i_valid     in   1           byte strobe from the terminal UART (one cycle per byte)
// - i_data      in   BYTE_WIDTH  byte to transmit; sampled when i_valid=1
// - o_tx        out  1           serial line; idles high
// - o_busy      out  1           1 = FIFO non-empty OR FSM not in IDLE
// - o_full      out  1           FIFO count == FIFO_DEPTH
// - o_overflow  out  1           one-cycle pulse: a byte was dropped
// BEHAVIOUR
// - Reset:
//   - Clock: i_clk. Reset: i_rst, asynchronous, active-high.
//   - While i_rst is high: o_tx=1, o_busy=0, o_full=0, o_overflow=0, FIFO empty,
//     FSM=IDLE, baud counter=0.
//   - Reset mid-frame aborts the frame immediately; o_tx returns high asynchronously.
// - FIFO:
//   - Push on the edge where i_valid=1 and (!o_full OR a pop occurs on the same edge).
//   - Full with a simultaneous pop: the byte is accepted and the count is unchanged.
//   - Full with no pop: byte discarded; o_overflow=1 for exactly the next cycle.
//     FIFO contents are unchanged.
//   - Read/write pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
// - FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE).
//   - IDLE: o_tx=1. If FIFO non-empty at an edge: pop head into the shift register,
//     clear the baud counter, go to START.
//   - START: o_tx=0 for CLKS_PER_BIT cycles.
//   - DATA: o_tx=shift[0] for CLKS_PER_BIT cycles per bit. Shift right after each bit.
//     Bit index 0..7; leave after bit 7.
//   - STOP: o_tx=1 for CLKS_PER_BIT cycles. At the end:
//     - FIFO non-empty: pop and go straight to START (back-to-back, no idle gap).
//     - Otherwise go to IDLE.
// - Baud counter counts 0..CLKS_PER_BIT-1. State/bit advance on the edge where
//   counter == CLKS_PER_BIT-1.
// - Timing:
//   - o_tx is registered.
//   - i_valid sampled at edge k into an empty FIFO with the FSM in IDLE:
//     pop at edge k+1; o_tx falls after edge k+1.
//   - Frame length is exactly 10*CLKS_PER_BIT cycles.
// CONFIGURATION
// - UART_TX_PARITY_EN defined:
//   - PARITY state added between DATA and STOP.
//   - o_tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
//   - Frame becomes 11*CLKS_PER_BIT cycles.
// - Undefined: no PARITY state; 8N1 framing as above.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
// - Reset: hold i_rst; o_tx=1, o_busy=0, o_full=0. Assert i_rst mid-DATA:
//   o_tx=1 in the same cycle, FIFO empty.
// - Single byte: i_valid with i_data=8'hA5 at edge k.
//   - o_tx low from edge k+1 for 4 cycles.
//   - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
//   - Stop high 4 cycles; o_busy=0 after 40 cycles.
// - Back-to-back: push 8'h00 then 8'hFF on consecutive cycles.
//   - Second start bit begins immediately after the first stop bit; no extra idle cycles.
//   - Total 80 cycles.
// - Overflow: while frame 1 is active, push 5 more bytes.
//   - o_full=1 after the 4th; 5th dropped; o_overflow pulses once.
//   - Exactly 5 frames are transmitted in total.
// - Full plus pop: FIFO full and STOP ends on the same edge as i_valid.
//   - Byte accepted, o_overflow stays 0, count stays 4.
// - UART_TX_PARITY_EN defined: send 8'h07.
//   - Parity bit = 1; frame length 44 cycles.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte FIFO feeding an 8N1 UART transmitter (LSB first, CLKS_PER_BIT cycles per bit).
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BYTE_WIDTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [BYTE_WIDTH-1:0] i_data,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_full,
  output logic                  o_overflow
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BYTE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [BYTE_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, baud_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign baud_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push       = i_valid && (!fifo_full || pop);

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      ovf_q <= i_valid && fifo_full && !pop;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_mem[rd_ptr_q];
`endif
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BIT_W'(BYTE_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_mem[rd_ptr_q];
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so it changes on the same edge as the FSM.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign o_tx       = tx_q;
  assign o_busy     = !fifo_empty || (state_q != S_IDLE);
  assign o_full     = fifo_full;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: reset, single/back-to-back frames, overflow,
// full-with-pop acceptance, mid-frame reset, and the parity bit when UART_TX_PARITY_EN is set.
module tb_uart_tx_serializer;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned SLOTS = 11;
`else
  localparam int unsigned SLOTS = 10;
`endif
  localparam int unsigned FRAME = SLOTS * CPB;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       o_tx, o_busy, o_full, o_overflow;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int unsigned ovf_cnt;

  logic [7:0] exp_q [$];
  logic       stim_v   [0:63];
  logic [7:0] stim_d   [0:63];
  logic       full_log [0:63];
  logic       ovf_log  [0:63];
  logic       tx_log   [0:63];

  uart_tx_serializer #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_data    (data),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic clear_stim();
    for (int unsigned i = 0; i < 64; i++) begin
      stim_v[i] = 1'b0;
      stim_d[i] = 8'h00;
    end
  endtask

  // Caller drives the first byte before calling; j counts edges after that byte is sampled.
  task automatic run_frames(input string tag);
    int unsigned last;
    last    = exp_q.size() * FRAME;
    ovf_cnt = 0;
    for (int unsigned j = 0; j <= last + 1; j++) begin
      @(negedge clk);
      if (j < 64) begin
        full_log[j] = o_full;
        ovf_log[j]  = o_overflow;
        tx_log[j]   = o_tx;
      end
      if (o_overflow) ovf_cnt++;
      if (j >= 1 && j <= last)
        chk($sformatf("%s_tx_%0d", tag, j), {31'd0, o_tx},
            {31'd0, frame_bit(exp_q[(j-1)/FRAME], ((j-1)%FRAME)/CPB)});
      if (j == last) chk($sformatf("%s_busy_end", tag), {31'd0, o_busy}, 32'd1);
      if (j == last + 1) begin
        chk($sformatf("%s_idle_busy", tag), {31'd0, o_busy}, 32'd0);
        chk($sformatf("%s_idle_tx", tag), {31'd0, o_tx}, 32'd1);
      end
      valid = (j < 64) ? stim_v[j] : 1'b0;
      data  = (j < 64) ? stim_d[j] : 8'h00;
    end
  endtask

  initial begin
    // Reset, with a strobe that must be ignored
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
    valid = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", {31'd0, o_tx}, 32'd1);
    chk("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // Single byte A5
    clear_stim();
    exp_q = '{8'hA5};
    valid = 1'b1;
    data  = 8'hA5;
    run_frames("single");
    chk("a5_start", {31'd0, tx_log[2]}, 32'd0);
    chk("a5_b0", {31'd0, tx_log[6]}, 32'd1);
    chk("a5_b1", {31'd0, tx_log[10]}, 32'd0);
    chk("a5_b2", {31'd0, tx_log[14]}, 32'd1);
    chk("a5_b6", {31'd0, tx_log[30]}, 32'd0);
    chk("a5_b7", {31'd0, tx_log[34]}, 32'd1);
    repeat (2) @(negedge clk);

    // Back-to-back 00 then FF
    clear_stim();
    stim_v[0] = 1'b1;
    stim_d[0] = 8'hFF;
    exp_q = '{8'h00, 8'hFF};
    valid = 1'b1;
    data  = 8'h00;
    run_frames("b2b");
    chk("b2b_stop1", {31'd0, tx_log[40]}, 32'd1);
    chk("b2b_start2", {31'd0, tx_log[41]}, 32'd0);
    repeat (2) @(negedge clk);

    // Overflow: 11 starts, then 22..66 pushed during frame 1; 66 dropped
    clear_stim();
    stim_v[1] = 1'b1; stim_d[1] = 8'h22;
    stim_v[2] = 1'b1; stim_d[2] = 8'h33;
    stim_v[3] = 1'b1; stim_d[3] = 8'h44;
    stim_v[4] = 1'b1; stim_d[4] = 8'h55;
    stim_v[5] = 1'b1; stim_d[5] = 8'h66;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    valid = 1'b1;
    data  = 8'h11;
    run_frames("ovf");
    chk("ovf_full_3", {31'd0, full_log[4]}, 32'd0);
    chk("ovf_full_4", {31'd0, full_log[5]}, 32'd1);
    chk("ovf_pulse_pre", {31'd0, ovf_log[5]}, 32'd0);
    chk("ovf_pulse", {31'd0, ovf_log[6]}, 32'd1);
    chk("ovf_pulse_post", {31'd0, ovf_log[7]}, 32'd0);
    chk("ovf_count", ovf_cnt, 32'd1);
    repeat (2) @(negedge clk);

    // Full FIFO with a push on the edge where STOP ends and pops
    clear_stim();
    stim_v[0]  = 1'b1; stim_d[0]  = 8'h22;
    stim_v[1]  = 1'b1; stim_d[1]  = 8'h33;
    stim_v[2]  = 1'b1; stim_d[2]  = 8'h44;
    stim_v[3]  = 1'b1; stim_d[3]  = 8'h55;
    stim_v[40] = 1'b1; stim_d[40] = 8'h66;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    valid = 1'b1;
    data  = 8'h11;
    run_frames("fullpop");
    chk("fullpop_full_early", {31'd0, full_log[4]}, 32'd1);
    chk("fullpop_full_before", {31'd0, full_log[40]}, 32'd1);
    chk("fullpop_full_after", {31'd0, full_log[41]}, 32'd1);
    chk("fullpop_no_ovf", {31'd0, ovf_log[41]}, 32'd0);
    chk("fullpop_ovf_count", ovf_cnt, 32'd0);
    repeat (2) @(negedge clk);

    // Byte 07: parity slot (or stop) is high either way
    clear_stim();
    exp_q = '{8'h07};
    valid = 1'b1;
    data  = 8'h07;
    run_frames("b07");
    chk("b07_b0", {31'd0, tx_log[5]}, 32'd1);
    chk("b07_b3", {31'd0, tx_log[17]}, 32'd0);
    chk("b07_slot9", {31'd0, tx_log[38]}, 32'd1);
    repeat (2) @(negedge clk);

    // Reset mid-DATA on a zero bit, with a second byte queued
    valid = 1'b1;
    data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_tx_low", {31'd0, o_tx}, 32'd0);
    chk("mid_busy", {31'd0, o_busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, o_tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_full", {31'd0, o_full}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("after_rst_tx", {31'd0, o_tx}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
